ex_mdu: RTL and testbench

RV32M multiply/divide execution unit, parametrised in data width, sitting beside the integer EX stage. It accepts one M-extension op at a time (opcode 0110011, funct7 0000001) and computes the result over multiple cycles. While busy it raises hold_flag_o so ctrl stalls the front of the pipeline. On completion it returns rd write-back data for one cycle.

---
 rtl/ex_mdu.sv | 173 +++++++++++++++++
 tb/tb_ex_mdu.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mdu.sv
// RV32M/RV64M multiply/divide unit beside the EX stage: one op at a time,
// multi-cycle, with a stall request while busy and a one-cycle write-back strobe.
module ex_mdu #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            hold_flag_o,
  output logic            done_o,
  output logic            rd_wen_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  logic [1:0]      f3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] op1_q;
  logic [XLEN-1:0] op2_q;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvsr;
  logic            neg_q;
  logic            neg_r;

  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [XLEN-1:0] special_res(input logic is_rem, input logic div0,
                                                  input logic [XLEN-1:0] op1);
    if (div0) return is_rem ? op1 : '1;
    return is_rem ? '0 : op1;
  endfunction

  // Accept-time decode
  logic accept;
  logic sgn_in;
  logic div0_in;
  logic ovf_in;
  logic special_in;

  assign accept     = (state == S_IDLE) && valid_i && !flush_i;
  assign sgn_in     = !funct3_i[0];
  assign div0_in    = (op2_i == '0);
  assign ovf_in     = sgn_in && (op1_i == INT_MIN) && (op2_i == '1);
  assign special_in = funct3_i[2] && (div0_in || ovf_in);

  assign hold_flag_o = accept || (state == S_MUL) || (state == S_DIV);
  assign busy_o      = (state != S_IDLE);
  assign rd_wen_o    = done_o;

  // Multiply: operands extended to 2*XLEN so one modular product covers all variants
  logic                   a_sgn;
  logic                   b_sgn;
  logic signed [2*XLEN-1:0] a_ext;
  logic signed [2*XLEN-1:0] b_ext;
  logic signed [2*XLEN-1:0] prod;
  logic [XLEN-1:0]        mul_res;

  assign a_sgn   = (f3_q == 2'd1) || (f3_q == 2'd2);
  assign b_sgn   = (f3_q == 2'd1);
  assign a_ext   = {{XLEN{a_sgn & op1_q[XLEN-1]}}, op1_q};
  assign b_ext   = {{XLEN{b_sgn & op2_q[XLEN-1]}}, op2_q};
  assign prod    = a_ext * b_ext;
  assign mul_res = (f3_q == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Restoring divide step; remainder stays below the divisor, so one extra bit suffices
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] div_res;

  assign rem_sh  = {rem, quo[XLEN-1]};
  assign diff    = rem_sh - {1'b0, dvsr};
  assign fits    = !diff[XLEN];
  assign rem_nx  = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nx  = {quo[XLEN-2:0], fits};
  assign div_res = f3_q[1] ? apply_sign(rem_nx, neg_r) : apply_sign(quo_nx, neg_q);

  // Operand / datapath registers (no reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      f3_q  <= funct3_i[1:0];
      rd_q  <= rd_addr_i;
      op1_q <= op1_i;
      op2_q <= op2_i;
      quo   <= apply_sign(op1_i, sgn_in && op1_i[XLEN-1]);
      dvsr  <= apply_sign(op2_i, sgn_in && op2_i[XLEN-1]);
      rem   <= '0;
      neg_q <= sgn_in && (op1_i[XLEN-1] ^ op2_i[XLEN-1]);
      neg_r <= sgn_in && op1_i[XLEN-1];
    end else if (state == S_DIV) begin
      quo <= quo_nx;
      rem <= rem_nx;
    end
  end

  // Control FSM and registered write-back outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      done_o    <= 1'b0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
    end else begin
      done_o    <= 1'b0;
      rd_data_o <= '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (!funct3_i[2]) begin
              state <= S_MUL;
              cnt   <= CW'(MUL_LAT - 1);
            end else if (special_in) begin
              state     <= S_DONE;
              done_o    <= 1'b1;
              rd_addr_o <= rd_addr_i;
              rd_data_o <= special_res(funct3_i[1], div0_in, op1_i);
            end else begin
              state <= S_DIV;
              cnt   <= CW'(XLEN);
            end
          end
        end
        S_MUL: begin
          if (flush_i) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            state     <= S_DONE;
            done_o    <= 1'b1;
            rd_addr_o <= rd_q;
            rd_data_o <= mul_res;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DIV: begin
          if (flush_i) begin
            state <= S_IDLE;
          end else if (cnt == CW'(1)) begin
            state     <= S_DONE;
            done_o    <= 1'b1;
            rd_addr_o <= rd_q;
            rd_data_o <= div_res;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Bench for ex_mdu: directed corner cases plus randomized ops against a
// plain-arithmetic reference of the RV32M result and latency rules.
module tb_ex_mdu;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            busy_o;
  logic            hold_flag_o;
  logic            done_o;
  logic            rd_wen_o;
  logic [4:0]      rd_addr_o;
  logic [XLEN-1:0] rd_data_o;

  int n_cmp = 0;
  int n_bad = 0;

  ex_mdu #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .funct3_i(funct3_i),
    .op1_i(op1_i), .op2_i(op2_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
    .busy_o(busy_o), .hold_flag_o(hold_flag_o), .done_o(done_o),
    .rd_wen_o(rd_wen_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference result straight from the RV32M definitions
  function automatic logic [31:0] ref_res(input int f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (f3)
      0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      1: begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
      2: begin p = longint'($signed(a)) * longint'({32'b0, b}); return p[63:32]; end
      3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input int f3, input logic [31:0] a, input logic [31:0] b);
    if (f3 < 4) return MUL_LAT + 1;
    if (b == 0) return 1;
    if ((f3 == 4 || f3 == 6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Called just after a negedge; returns just after the negedge of the idle cycle after DONE
  task automatic run_op(input string tag, input int f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int cyc;
    int hold_bad;
    logic [4:0] rd;
    bit got;
    rd        = 5'($urandom);
    funct3_i  = 3'(f3);
    op1_i     = a;
    op2_i     = b;
    rd_addr_i = rd;
    valid_i   = 1'b1;
    #1 chk({tag, "_hold0"}, 64'(hold_flag_o), 64'd1);
    @(posedge clk);
    #1;
    op1_i    = $urandom;
    op2_i    = $urandom;
    funct3_i = 3'($urandom);
    cyc      = 0;
    hold_bad = 0;
    got      = 0;
    while (!got && cyc < 100) begin
      valid_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
      if (done_o) got = 1;
      else if (!hold_flag_o || !busy_o) hold_bad++;
    end
    valid_i = 1'b0;
    chk({tag, "_lat"}, 64'(cyc), 64'(lat));
    chk({tag, "_data"}, 64'(rd_data_o), 64'(exp));
    chk({tag, "_rd"}, 64'(rd_addr_o), 64'(rd));
    chk({tag, "_wen"}, 64'(rd_wen_o), 64'd1);
    chk({tag, "_holddone"}, 64'(hold_flag_o), 64'd0);
    chk({tag, "_holdbusy"}, 64'(hold_bad), 64'd0);
    @(negedge clk);
    chk({tag, "_idle"}, 64'({busy_o, done_o, rd_wen_o}), 64'd0);
    chk({tag, "_zero"}, 64'(rd_data_o), 64'd0);
  endtask

  typedef struct {
    int          f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
    funct3_i = '0; op1_i = '0; op2_i = '0; rd_addr_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ctl", 64'({busy_o, hold_flag_o, done_o, rd_wen_o}), 64'd0);
    chk("reset_rd", 64'(rd_addr_o), 64'd0);
    chk("reset_data", 64'(rd_data_o), 64'd0);

    // Reset pulsed in cycle 1 of a MUL
    funct3_i = 3'd0; op1_i = 32'd3; op2_i = 32'd5; rd_addr_i = 5'd9; valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    @(negedge clk);
    chk("rstmid_busy1", 64'(busy_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_busy0", 64'(busy_o), 64'd0);
    begin
      int seen = 0;
      repeat (6) begin
        @(negedge clk);
        if (done_o || busy_o) seen++;
      end
      chk("rstmid_nodone", 64'(seen), 64'd0);
    end

    vecs.push_back('{0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 3});
    vecs.push_back('{3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 3});
    vecs.push_back('{1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 3});
    vecs.push_back('{2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 3});
    vecs.push_back('{4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33});
    vecs.push_back('{6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33});
    vecs.push_back('{5, 32'd100,        32'd7,         32'd14,        33});
    vecs.push_back('{7, 32'd100,        32'd7,         32'd2,         33});
    vecs.push_back('{5, 32'h1234,       32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{7, 32'h1234,       32'd0,         32'h1234,      1});
    vecs.push_back('{4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1});
    vecs.push_back('{4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1});
    foreach (vecs[i])
      run_op($sformatf("dir%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Flush in cycle 10 of a divide, then a fresh op in cycle 11
    funct3_i = 3'd5; op1_i = 32'd1000; op2_i = 32'd3; rd_addr_i = 5'd4; valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    begin
      int seen = 0;
      repeat (9) begin
        @(negedge clk);
        if (done_o) seen++;
      end
      flush_i = 1'b1;
      @(posedge clk);
      #1 flush_i = 1'b0;
      @(negedge clk);
      chk("flush_busy", 64'(busy_o), 64'd0);
      chk("flush_nodone", 64'(seen + int'(done_o)), 64'd0);
    end
    run_op("after_flush", 5, 32'd1000, 32'd3, 32'd333, 33);

    // valid with flush in IDLE is not accepted
    funct3_i = 3'd0; op1_i = 32'd2; op2_i = 32'd2; valid_i = 1'b1; flush_i = 1'b1;
    #1 chk("vflush_hold", 64'(hold_flag_o), 64'd0);
    @(posedge clk);
    #1 begin valid_i = 1'b0; flush_i = 1'b0; end
    @(negedge clk);
    chk("vflush_busy", 64'(busy_o), 64'd0);

    for (int i = 0; i < 150; i++) begin
      int f3;
      int m;
      logic [31:0] a;
      logic [31:0] b;
      f3 = $urandom_range(0, 7);
      m  = $urandom_range(0, 9);
      a  = $urandom;
      b  = $urandom;
      if (m == 0) b = 32'd0;
      else if (m == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (m == 2) begin a = 32'($urandom_range(0, 200)) - 32'd100; b = 32'($urandom_range(1, 20)); end
      else if (m == 3) b = 32'($urandom_range(1, 9)) * ((m & 1) ? 32'd1 : 32'hFFFF_FFFF);
      run_op($sformatf("rnd%0d_f%0d", i, f3), f3, a, b, ref_res(f3, a, b), ref_lat(f3, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
